// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arbiter_pkg;

    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int CNT_W           = 3;
    localparam int WAIT_CYCLES_DEF = 2;

    // Arbiter FSM states: idle or one of the three access kinds.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_ACC = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } arb_state_t;

    // Which requester owned the most recent grant; drives the fairness rule.
    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

    // Active-low SRAM strobes kept together so they are always updated as a set.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } strobe_t;

    localparam strobe_t STB_IDLE    = 3'b111;
    localparam strobe_t STB_READ    = 3'b001;
    localparam strobe_t STB_WRITE   = 3'b010;
    localparam strobe_t STB_WR_HOLD = 3'b011;

    localparam logic [DATA_W-1:0] NOP_INST = '0;

    // Strobe pattern for a given state; the last write cycle releases we_n
    // early so the data bus is still driven while the write edge closes.
    function automatic strobe_t strobe_for(input arb_state_t st, input logic last_cycle);
        strobe_t s;
        case (st)
            ST_IF_ACC, ST_MEM_RD: s = STB_READ;
            ST_MEM_WR:            s = last_cycle ? STB_WR_HOLD : STB_WRITE;
            default:              s = STB_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one asynchronous SRAM between instruction fetch and MEM-stage data accesses.
// Latency: each access holds the SRAM for WAIT_CYCLES cycles; if_valid/mem_done pulse the cycle after.
// Backpressure: stall_req holds the pipeline while any request is pending without its completion pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall_req
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t       state_q, state_d, pick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    gnt_t             last_gnt_q, last_gnt_d;
    strobe_t          stb_q, stb_d;
    logic             last_cycle;
    logic             grant_win;

    assign last_cycle = (state_q != ST_IDLE) && (cnt_q == LAST_CNT);
    assign grant_win  = (state_q == ST_IDLE) || last_cycle;

    // Requester selection: MEM first, but yield to IF right after a MEM access.
    always_comb begin
        pick = ST_IDLE;
        if (mem_req && (!if_req || (last_gnt_q == GNT_IF))) begin
            pick = mem_we ? ST_MEM_WR : ST_MEM_RD;
        end else if (if_req) begin
            pick = ST_IF_ACC;
        end
    end

    // Next state, access counter and the strobes for the coming cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        if (grant_win) begin
            state_d = pick;
            cnt_d   = '0;
            if (pick == ST_IF_ACC) begin
                last_gnt_d = GNT_IF;
            end else if (pick != ST_IDLE) begin
                last_gnt_d = GNT_MEM;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        stb_d = strobe_for(state_d, cnt_d == LAST_CNT);
    end

    // FSM state, counter, grant history and registered strobes; reset aborts any access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_gnt_q <= GNT_IF;
            stb_q      <= STB_IDLE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            stb_q      <= stb_d;
        end
    end

    // Latch the winning request's address and write data for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else if (grant_win && (pick != ST_IDLE)) begin
            sram_addr <= (pick == ST_IF_ACC) ? if_addr : mem_addr;
            if (pick == ST_MEM_WR) begin
                sram_wdata <= mem_wdata;
            end
        end
    end

    // Capture read data at the end of the final access cycle and pulse completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_inst   <= NOP_INST;
            mem_rdata <= '0;
            if_valid  <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            mem_done <= 1'b0;
            if (last_cycle) begin
                case (state_q)
                    ST_IF_ACC: begin
                        if_inst  <= sram_rdata;
                        if_valid <= 1'b1;
                    end
                    ST_MEM_RD: begin
                        mem_rdata <= sram_rdata;
                        mem_done  <= 1'b1;
                    end
                    ST_MEM_WR: begin
                        mem_done <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sram_ce_n = stb_q.ce_n;
    assign sram_oe_n = stb_q.oe_n;
    assign sram_we_n = stb_q.we_n;

    assign stall_req = (if_req && !if_valid) || (mem_req && !mem_done);

endmodule
